mm_control: RTL and testbench



---
 rtl/mm_control.sv | 63 ++++++
 tb/tb_mm_control.sv | 104 ++++++++++
 2 files changed

// File: rtl/mm_control.sv
// mm_control: 4x4 matmul sequencer driving X/A read addresses, MAC control and P writes; MM_CTRL_DONE_EN adds a done output
module mm_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  output logic       result_en,
  output logic       control,
  output logic [3:0] addr_x,
  output logic [3:0] addr_A,
  output logic [3:0] addr_P
`ifdef MM_CTRL_DONE_EN
  ,
  output logic       done
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     r_state;
  logic [5:0] r_t;
  logic       r_result_en, r_control;
  logic [3:0] r_addr_x, r_addr_A, r_addr_P;
  logic [5:0] w_tn;
  assign w_tn      = r_t + 6'd1;
  assign result_en = r_result_en;
  assign control   = r_control;
  assign addr_x    = r_addr_x;
  assign addr_A    = r_addr_A;
  assign addr_P    = r_addr_P;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_t         <= '0;
      r_result_en <= 1'b0;
      r_control   <= 1'b0;
      r_addr_x    <= '0;
      r_addr_A    <= '0;
      r_addr_P    <= '0;
    end else begin
      r_result_en <= 1'b0;
      case (r_state)
        IDLE: r_state <= Start ? RUN : IDLE;
        RUN: begin
          r_t         <= w_tn;
          r_result_en <= &r_t[1:0];
          if (&r_t[1:0]) r_addr_P <= r_t[5:2];
          r_state     <= &r_t ? DONE : RUN;
          r_addr_x    <= &r_t ? 4'd0 : {w_tn[5:4], w_tn[1:0]};
          r_addr_A    <= &r_t ? 4'd0 : {w_tn[1:0], w_tn[3:2]};
          r_control   <= &r_t ? 1'b0 : |w_tn[1:0];
        end
        DONE: r_state <= Start ? DONE : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef MM_CTRL_DONE_EN
  logic r_done;
  assign done = r_done;
  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else r_done <= (r_state == DONE) && Start;
  end
`endif
endmodule

// File: tb/tb_mm_control.sv
// tb_mm_control: randomized and directed check of mm_control against an arithmetic reference model
module tb_mm_control;
  logic       clk, rst, Start;
  logic       result_en, control;
  logic [3:0] addr_x, addr_A, addr_P;
  int vectors = 0, errs = 0;
  int mode = 0, n = 0, cyc_cnt = 0;
  logic       m_pe = 1'b0;
  logic [3:0] m_pa = 4'd0;
  int dut_pulses = 0, last_pulse = -1;
  logic [3:0] last_pa = 4'd0;
  mm_control dut (
    .clk(clk), .rst(rst), .Start(Start), .result_en(result_en), .control(control),
    .addr_x(addr_x), .addr_A(addr_A), .addr_P(addr_P)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    assert (act === exp) else begin
      errs++;
      $error("FAIL %s got %0d expected %0d at cycle %0d", tag, act, exp, cyc_cnt);
    end
  endtask
  task automatic model_step(input logic r, input logic s);
    if (r === 1'b1) begin
      mode = 0; n = 0; m_pe = 1'b0; m_pa = 4'd0;
    end else if (mode == 0) begin
      m_pe = 1'b0;
      if (s === 1'b1) begin mode = 1; n = 0; end
    end else if (mode == 1) begin
      m_pe = (n % 4 == 3);
      if (m_pe) m_pa = 4'(n / 4);
      n++;
      if (n == 64) begin mode = 2; n = 0; end
    end else begin
      m_pe = 1'b0;
      if (s !== 1'b1) mode = 0;
    end
  endtask
  task automatic check_all();
    int ex, ea;
    logic ec;
    ex = (mode == 1) ? (n / 16) * 4 + n % 4 : 0;
    ea = (mode == 1) ? (n % 4) * 4 + (n / 4) % 4 : 0;
    ec = (mode == 1) && (n % 4 != 0);
    chk("result_en", {7'd0, result_en}, {7'd0, m_pe});
    chk("control", {7'd0, control}, {7'd0, ec});
    chk("addr_x", {4'd0, addr_x}, 8'(ex));
    chk("addr_A", {4'd0, addr_A}, 8'(ea));
    chk("addr_P", {4'd0, addr_P}, {4'd0, m_pa});
  endtask
  task automatic cyc(input logic r, input logic s);
    rst = r;
    Start = s;
    @(posedge clk);
    cyc_cnt++;
    model_step(r, s);
    #1;
    check_all();
    if (result_en === 1'b1) begin
      dut_pulses++;
      last_pa = addr_P;
    end
  endtask
  initial begin
    int guard;
    rst = 1'b1;
    Start = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'bx);
    dut_pulses = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b1);
      if (mode == 1 && n == 22) begin
        chk("t22_addr_x", {4'd0, addr_x}, 8'd6);
        chk("t22_addr_A", {4'd0, addr_A}, 8'd9);
        chk("t22_control", {7'd0, control}, 8'd1);
      end
      if (result_en === 1'b1) begin
        if (last_pulse >= 0) chk("pulse_spacing", 8'(cyc_cnt - last_pulse), 8'd4);
        last_pulse = cyc_cnt;
      end
    end
    chk("pulses_held_start", 8'(dut_pulses), 8'd16);
    chk("last_addr_P", {4'd0, last_pa}, 8'd15);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    dut_pulses = 0;
    guard = 0;
    do begin
      cyc(1'b0, 1'b1);
      guard++;
    end while (!(mode == 1 && n == 30) && guard < 100);
    chk("reach_t30", 8'(guard < 100), 8'd1);
    chk("pulses_before_abort", 8'(dut_pulses), 8'd7);
    cyc(1'b1, 1'b1);
    dut_pulses = 0;
    for (int i = 0; i < 80; i++) cyc(1'b0, 1'b1);
    chk("pulses_after_restart", 8'(dut_pulses), 8'd16);
    for (int i = 0; i < 800; i++)
      cyc(($urandom % 300) == 0, ($urandom % 4) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
